prng_checker: RTL
=================

Name: prng_checker

Overview:
- Receive-side checker for the 32-bit PRNG word stream: it is the consumer of the generator's data output.
- Self-synchronises by seeding a local LFSR model from an observed word. It then predicts each following word and flags mismatches.
- It keeps error and word statistics. It is used in bring-up benches and as an on-chip link/BIST monitor.

Parameters:
- WIDTH, 32: data word width.
- POLY, 32'h8020_0003: Galois feedback mask. This is the same polynomial the PRNG uses.
- LOCK_CNT, 4: consecutive correct predictions needed to declare lock (range 1..15).
- LOSS_CNT, 3: consecutive mismatches while locked that drop lock (range 1..15).
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ivalid  input  1  idata carries a new PRNG word this cycle.
- idata  input  WIDTH  observed PRNG word.
- iclr  input  1  synchronous clear of statistics and capture. Lock state is unaffected.
- locked  output  1  checker is locked to the stream.
- err  output  1  one-cycle pulse on a mismatch while locked.
- err_cnt  output  CNT_W  saturating mismatch count.
- word_cnt  output  CNT_W  saturating count of words checked while locked.
- cap_valid  output  1  first-error capture is valid.
- cap_exp  output  WIDTH  expected word at the first error.
- cap_got  output  WIDTH  received word at the first error.

Behaviour:
- Reset values: all outputs 0; state SEARCH; exp = 0; match_cnt = miss_cnt = 0.
- Asynchronous reset mid-stream aborts everything. Re-synchronisation restarts from SEARCH.
- Next-state function: nxt(s) = (s >> 1) ^ (s[0] ? POLY : 0).
- Zero word: 0 is the LFSR lock-up state. A zero word is never used as a seed.
- Timing: only cycles with ivalid = 1 advance the checker; ivalid = 0 holds all state.
- Latency: all outputs are registered. Each reflects the word sampled at the preceding edge, i.e. one cycle of latency.
- SEARCH:
  - On a valid non-zero word: exp <= nxt(idata), match_cnt <= 0, go to VERIFY.
  - On a zero word: stay in SEARCH.
- VERIFY, on a valid word:
  - If idata == exp: exp <= nxt(idata), match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED, set locked = 1, miss_cnt <= 0.
  - Else, if idata is non-zero: re-seed with exp <= nxt(idata), match_cnt <= 0, stay in VERIFY.
  - Else (zero word): go to SEARCH.
  - No err pulses are generated in VERIFY.
- LOCKED, on a valid word:
  - exp <= nxt(exp). This is a flywheel: the next prediction comes from exp, never from idata.
  - Match: miss_cnt <= 0, word_cnt++.
  - Mismatch: err = 1 for one cycle, err_cnt++, word_cnt++, miss_cnt++.
  - When miss_cnt reaches LOSS_CNT: go to SEARCH, locked = 0, miss_cnt <= 0. The err pulse for that word is still issued.
- Counters:
  - err_cnt and word_cnt saturate at all-ones and never wrap.
  - iclr zeroes err_cnt, word_cnt and cap_valid.
  - If iclr and a counted word arrive in the same cycle, iclr wins: the counter reads 0 next cycle.
- Lock loss: locked falls in the same cycle as the final err pulse.
- The PRNG seed-load pulse (its ivalid/seed) is not observed. A re-seed appears as a mismatch burst, after which the checker re-locks automatically.

Optional Feature:
- Macro: PRNG_CHK_CAPTURE_EN.
- Defined:
  - On the first mismatch while locked with cap_valid = 0: cap_exp <= exp, cap_got <= idata, cap_valid <= 1.
  - Later errors do not overwrite the capture. iclr re-arms it.
- Undefined: cap_valid, cap_exp and cap_got are tied to 0 and no capture registers are built.

Test Plan:
- Lock-in: feed 0x00000001, 0x80200003, 0xC0300002, 0x60180001, 0xB02C0003 on consecutive cycles -> locked rises one cycle after the 5th word; err stays 0; err_cnt = 0, word_cnt = 0.
- Single error: once locked, replace one word by its value XOR 0x1 -> exactly one err pulse; err_cnt = 1; locked stays 1; the next correct words give no error.
  - With PRNG_CHK_CAPTURE_EN defined: cap_exp = expected word, cap_got = corrupted word.
- Lock loss and re-seed: switch the stream to a new seed 0x12345678 while locked -> 3 err pulses, then locked = 0. After 5 words of the new stream, locked = 1 again; err_cnt = 3.
- Gaps and zero: insert ivalid = 0 bubbles between words -> no state change. A zero word in SEARCH keeps the checker in SEARCH with locked = 0.
- Saturation and clear: with CNT_W = 4, feed 20 locked words -> word_cnt = 15. Assert iclr together with a valid word -> word_cnt = 0 next cycle and cap_valid = 0.
- Reset: assert rst_n low mid-LOCKED, asynchronously -> all outputs are 0 immediately. After release, the checker needs a full lock-in sequence again.

Source files
------------

// File: rtl/prng_checker.sv
// Receive-side checker for a 32-bit Galois-LFSR word stream: self-seeds, locks, flags mismatches.
// Optional first-error capture registers are built when PRNG_CHK_CAPTURE_EN is defined.
module prng_checker #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  POLY     = 32'h8020_0003,
    parameter int unsigned       LOCK_CNT = 4,
    parameter int unsigned       LOSS_CNT = 3,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ivalid,
    input  logic [WIDTH-1:0]  idata,
    input  logic              iclr,
    output logic              locked,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              cap_valid,
    output logic [WIDTH-1:0]  cap_exp,
    output logic [WIDTH-1:0]  cap_got
);

    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] w_exp_nxt;
    logic [RUN_W-1:0] r_match_cnt;
    logic [RUN_W-1:0] w_match_nxt;
    logic [RUN_W-1:0] r_miss_cnt;
    logic [RUN_W-1:0] w_miss_nxt;
    logic             w_hit;
    logic             w_err_inc;
    logic             w_word_inc;

    function automatic logic [WIDTH-1:0] f_nxt(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    // Next-state: SEARCH seeds, VERIFY confirms, LOCKED flywheels on the local prediction
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err_inc   = 1'b0;
        w_word_inc  = 1'b0;
        w_hit       = (idata == r_exp);
        if (ivalid) begin
            case (r_state)
                S_SEARCH: begin
                    if (idata != '0) begin
                        w_exp_nxt   = f_nxt(idata);
                        w_match_nxt = '0;
                        w_state_nxt = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (w_hit) begin
                        w_exp_nxt   = f_nxt(idata);
                        w_match_nxt = r_match_cnt + RUN_W'(1);
                        if (w_match_nxt == RUN_W'(LOCK_CNT)) begin
                            w_state_nxt = S_LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else if (idata != '0) begin
                        w_exp_nxt   = f_nxt(idata);
                        w_match_nxt = '0;
                    end else begin
                        w_state_nxt = S_SEARCH;
                    end
                end
                S_LOCKED: begin
                    w_exp_nxt  = f_nxt(r_exp);
                    w_word_inc = 1'b1;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_inc  = 1'b1;
                        w_miss_nxt = r_miss_cnt + RUN_W'(1);
                        if (w_miss_nxt == RUN_W'(LOSS_CNT)) begin
                            w_state_nxt = S_SEARCH;
                            w_miss_nxt  = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SEARCH;
            r_exp       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            locked      <= (w_state_nxt == S_LOCKED);
            err         <= w_err_inc;
        end
    end

    // Saturating statistics; clear takes priority over a same-cycle count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            word_cnt <= '0;
        end else if (iclr) begin
            err_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (w_err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (w_word_inc && (word_cnt != '1)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PRNG_CHK_CAPTURE_EN
    logic             r_cap_valid;
    logic [WIDTH-1:0] r_cap_exp;
    logic [WIDTH-1:0] r_cap_got;

    // First-error capture, re-armed only by iclr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_valid <= 1'b0;
            r_cap_exp   <= '0;
            r_cap_got   <= '0;
        end else if (iclr) begin
            r_cap_valid <= 1'b0;
        end else if (w_err_inc && !r_cap_valid) begin
            r_cap_valid <= 1'b1;
            r_cap_exp   <= r_exp;
            r_cap_got   <= idata;
        end
    end

    assign cap_valid = r_cap_valid;
    assign cap_exp   = r_cap_exp;
    assign cap_got   = r_cap_got;
`else
    assign cap_valid = 1'b0;
    assign cap_exp   = '0;
    assign cap_got   = '0;
`endif

endmodule
